// File: rtl/hc595_seg_pkg.sv
// hc595_seg_pkg: active-low segment glyphs and scan FSM states for the 74HC595 display driver
package hc595_seg_pkg;
    localparam logic [7:0] SEG_0 = 8'hc0;
    localparam logic [7:0] SEG_1 = 8'hf9;
    localparam logic [7:0] SEG_2 = 8'ha4;
    localparam logic [7:0] SEG_3 = 8'hb0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hf8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hc6;
    localparam logic [7:0] SEG_D = 8'ha1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8e;
    localparam logic [7:0] SEG_DASH = 8'hbf;
    localparam logic [7:0] SEG_BLANK = 8'hff;
    localparam int DP_BIT = 7;
    typedef enum logic [1:0] {LOAD, SHIFT, LATCH, GAP} state_t;
endpackage

// File: rtl/hc595_seg_decode.sv
// hc595_seg_decode: digit code to active-low segment byte with dp and blanking
module hc595_seg_decode
    import hc595_seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    logic [7:0] glyph;
    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'ha: glyph = HEX_MODE != 0 ? SEG_A : SEG_DASH;
            4'hb: glyph = HEX_MODE != 0 ? SEG_B : SEG_BLANK;
            4'hc: glyph = HEX_MODE != 0 ? SEG_C : SEG_BLANK;
            4'hd: glyph = HEX_MODE != 0 ? SEG_D : SEG_BLANK;
            4'he: glyph = HEX_MODE != 0 ? SEG_E : SEG_BLANK;
            4'hf: glyph = HEX_MODE != 0 ? SEG_F : SEG_BLANK;
        endcase
    end
    assign seg = blank ? SEG_BLANK : glyph & ~({7'b0, dp} << DP_BIT);
endmodule

// File: rtl/hc595_seg_scan.sv
// hc595_seg_scan: time-multiplexed seven-segment scan over a 74HC595 {segment, select} chain
module hc595_seg_scan
    import hc595_seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 0,
    parameter int HEX_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     blank,
    output logic                  ser,
    output logic                  srclk,
    output logic                  rclk,
    output logic                  frame_done
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] P_RISE = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t        state;
    logic [IW-1:0] idx, nxt_idx;
    logic [PW-1:0] phase;
    logic [3:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [14:0]   sr;
    logic [7:0]    seg, sel;
    logic [15:0]   word;

    hc595_seg_decode #(.HEX_MODE(HEX_MODE)) u_decode (
        .code  (data[{idx, 2'b00} +: 4]),
        .dp    (dp_en[idx]),
        .blank (blank[idx]),
        .seg   (seg)
    );

    assign sel     = ~(8'h01 << idx);
    assign word    = {seg, sel};
    assign nxt_idx = idx == I_LAST ? '0 : idx + 1'b1;

    // Phase runs 0..2*CLK_DIV-1 per bit during SHIFT and 0..CLK_DIV-1 during LATCH.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= LOAD;
            idx        <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sr         <= '0;
            ser        <= 1'b0;
            srclk      <= 1'b0;
            rclk       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                LOAD: begin
                    sr      <= word[14:0];
                    ser     <= word[15];
                    phase   <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT:
                    if (phase != P_LAST) begin
                        phase <= phase + 1'b1;
                        srclk <= phase >= P_RISE;
                    end else begin
                        phase <= '0;
                        srclk <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state      <= LATCH;
                            ser        <= 1'b0;
                            rclk       <= 1'b1;
                            frame_done <= CLK_DIV == 1 && idx == I_LAST;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            ser     <= sr[14];
                            sr      <= {sr[13:0], 1'b0};
                        end
                    end
                LATCH:
                    if (phase != P_RISE) begin
                        phase      <= phase + 1'b1;
                        frame_done <= phase + 1'b1 == P_RISE && idx == I_LAST;
                    end else begin
                        rclk    <= 1'b0;
                        gap_cnt <= '0;
                        if (GAP_CYCLES > 0) state <= GAP;
                        else begin
                            state <= LOAD;
                            idx   <= nxt_idx;
                        end
                    end
                GAP:
                    if (gap_cnt != G_LAST) gap_cnt <= gap_cnt + 1'b1;
                    else begin
                        state <= LOAD;
                        idx   <= nxt_idx;
                    end
            endcase
        end
endmodule
